lut_sweeper: RTL

LUT_SWEEPER -- requirements
Module: lut_sweeper

---
 rtl/lut_sweeper.sv | 123 ++++++++++++
 1 files changed

// File: rtl/lut_sweeper.sv
// Truth-table sweeper: latches a 2^N-bit LUT on start and emits one minterm per cycle with a running ones count.
// Latency: start sampled at cycle k -> first minterm at k+1, done pulse at k+2^N+1; no backpressure, abort ends a sweep early.
// LUT_SWEEPER_GRAY_EN selects reflected Gray enumeration order instead of binary.
module lut_sweeper #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [2**N-1:0]  tt,
    output logic             busy,
    output logic             valid,
    output logic [N-1:0]     idx,
    output logic             s,
    output logic [N:0]       ones,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [N-1:0]    r_cnt;
    logic [2**N-1:0] r_tt_q;
    logic [N:0]      r_ones;

    logic [N-1:0]    w_code;
    logic            w_bit;
    logic            w_last;
    logic            w_load;
    logic            w_step;
    logic            w_count;

    // The counter always runs in binary; only the presented minterm code changes with the order.
`ifdef LUT_SWEEPER_GRAY_EN
    assign w_code = r_cnt ^ (r_cnt >> 1);
`else
    assign w_code = r_cnt;
`endif

    assign w_bit  = r_tt_q[w_code];
    assign w_last = (r_cnt == {N{1'b1}});
    assign ones   = r_ones;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        valid       = 1'b0;
        idx         = '0;
        s           = 1'b0;
        done        = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                busy  = 1'b1;
                valid = 1'b1;
                idx   = w_code;
                s     = w_bit;
                // The minterm shown in the abort cycle is not counted.
                if (abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step  = 1'b1;
                    w_count = w_bit;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tt_q <= '0;
            r_ones <= '0;
        end else begin
            if (w_load) begin
                r_cnt  <= '0;
                r_tt_q <= tt;
                r_ones <= '0;
            end else begin
                if (w_step) begin
                    r_cnt <= r_cnt + N'(1);
                end
                if (w_count) begin
                    r_ones <= r_ones + (N+1)'(1);
                end
            end
        end
    end

endmodule
